// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Registered execution stage. Logic, add/subtract, compare and undefined ops
// complete in one cycle. MUL (shift-add, LSB first) and DIV (restoring, MSB
// first) iterate for 32 cycles under a start/busy/done handshake.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request, accepted only while busy=0
//   aluOp      in   4   operation code, sampled with start
//   opA, opB   in  32   operands, sampled with start
//   result     out 32   result of the last completed operation
//   remainder  out 32   DIV remainder, 0 after any other op
//   zero       out  1   (result == 0)
//   busy       out  1   high while MUL/DIV iterates
//   done       out  1   one-cycle pulse when result/remainder/zero update
// -----------------------------------------------------------------------------
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  aluOp,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [31:0] result,
  output logic [31:0] remainder,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIVD = 2'b10
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  state_t      state_r;
  logic [4:0]  count_r;
  // MUL: a_r = shifting multiplicand, b_r = shifting multiplier, acc_r = sum.
  // DIV: a_r = dividend shifting out / quotient shifting in, b_r = divisor,
  //      acc_r = partial remainder.
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] acc_r;

  logic [31:0] simpleResult_s;
  logic [31:0] mulSum_s;
  logic [32:0] divTrial_s;
  logic        divFits_s;
  logic [31:0] divDiff_s;
  logic [31:0] divRem_s;
  logic [31:0] divQuot_s;

  // Single-cycle operation result from the live inputs.
  always_comb begin
    simpleResult_s = 32'h0000_0000;
    case (aluOp)
      OP_NOP:  simpleResult_s = 32'h0000_0000;
      OP_ADD:  simpleResult_s = opA + opB;
      OP_SUB:  simpleResult_s = opA - opB;
      OP_AND:  simpleResult_s = opA & opB;
      OP_OR:   simpleResult_s = opA | opB;
      OP_NOR:  simpleResult_s = ~(opA | opB);
      OP_SLT:  simpleResult_s = ($signed(opA) < $signed(opB)) ? 32'h0000_0001 : 32'h0000_0000;
      OP_XOR:  simpleResult_s = opA ^ opB;
      default: simpleResult_s = 32'h0000_0000;
    endcase
  end

  // One iteration step for both multiplier and divider.
  always_comb begin
    mulSum_s   = acc_r + (b_r[0] ? a_r : 32'h0000_0000);
    divTrial_s = {acc_r, a_r[31]};
    divFits_s  = (divTrial_s >= {1'b0, b_r});
    // When the divisor fits, the true difference is below b_r, so 32 bits hold it.
    divDiff_s  = divTrial_s[31:0] - b_r;
    if (divFits_s) begin
      divRem_s = divDiff_s;
    end else begin
      divRem_s = divTrial_s[31:0];
    end
    divQuot_s  = {a_r[30:0], divFits_s};
  end

  // Control FSM, iterative datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= 5'd0;
      a_r       <= 32'h0000_0000;
      b_r       <= 32'h0000_0000;
      acc_r     <= 32'h0000_0000;
      result    <= 32'h0000_0000;
      remainder <= 32'h0000_0000;
      zero      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if ((aluOp == OP_MUL) || (aluOp == OP_DIV)) begin
              a_r     <= opA;
              b_r     <= opB;
              acc_r   <= 32'h0000_0000;
              count_r <= 5'd0;
              busy    <= 1'b1;
              state_r <= (aluOp == OP_MUL) ? MULT : DIVD;
            end else begin
              result    <= simpleResult_s;
              remainder <= 32'h0000_0000;
              zero      <= (simpleResult_s == 32'h0000_0000);
              done      <= 1'b1;
            end
          end
        end
        MULT: begin
          acc_r   <= mulSum_s;
          a_r     <= a_r << 1;
          b_r     <= b_r >> 1;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            result    <= mulSum_s;
            remainder <= 32'h0000_0000;
            zero      <= (mulSum_s == 32'h0000_0000);
            busy      <= 1'b0;
            done      <= 1'b1;
            count_r   <= 5'd0;
            state_r   <= IDLE;
          end
        end
        DIVD: begin
          acc_r   <= divRem_s;
          a_r     <= divQuot_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            result    <= divQuot_s;
            remainder <= divRem_s;
            zero      <= (divQuot_s == 32'h0000_0000);
            busy      <= 1'b0;
            done      <= 1'b1;
            count_r   <= 5'd0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          count_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed-vector self-checking bench for alu_exec_unit. Inputs change on the
// falling edge or 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        zero;
  logic        busy;
  logic        done;

  int checkCount;
  int errorCount;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .aluOp     (aluOp),
    .opA       (opA),
    .opB       (opB),
    .result    (result),
    .remainder (remainder),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Single-cycle op: drive at the falling edge, check right after the next rising edge.
  task automatic runSimple(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expRes);
    @(negedge clk);
    start = 1'b1;
    aluOp = op;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    checkValue({tag, ".done"}, {31'd0, done}, 32'd1);
    checkValue({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkValue({tag, ".result"}, result, expRes);
    checkValue({tag, ".rem"}, remainder, 32'd0);
    checkValue({tag, ".zero"}, {31'd0, zero}, {31'd0, (expRes == 32'd0)});
  endtask

  // MUL/DIV: checks busy at accept, latency, busy duration and final values.
  // injectAt >= 0 pulses start with ADD 1+1 at that cycle of the iteration.
  // Returns 1 time unit after the done edge, with start low.
  task automatic runLong(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes,
                         input logic [31:0] expRem, input int injectAt);
    int cycles;
    int busyCycles;
    int overlap;
    @(negedge clk);
    start = 1'b1;
    aluOp = op;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkValue({tag, ".busyAtAccept"}, {31'd0, busy}, 32'd1);
    busyCycles = busy ? 1 : 0;
    cycles     = 0;
    overlap    = 0;
    while (cycles < 40) begin
      if (cycles == injectAt) begin
        start = 1'b1;
        aluOp = 4'b0001;
        opA   = 32'd1;
        opB   = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (done && busy) overlap++;
      if (done) break;
      if (busy) busyCycles++;
    end
    start = 1'b0;
    checkValue({tag, ".latency"}, cycles, 32'd32);
    checkValue({tag, ".busyCycles"}, busyCycles, 32'd32);
    checkValue({tag, ".doneBusyOverlap"}, overlap, 32'd0);
    checkValue({tag, ".busyAfter"}, {31'd0, busy}, 32'd0);
    checkValue({tag, ".result"}, result, expRes);
    checkValue({tag, ".rem"}, remainder, expRem);
    checkValue({tag, ".zero"}, {31'd0, zero}, {31'd0, (expRes == 32'd0)});
  endtask

  initial begin
    int doneSeen;
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    start = 1'b0;
    aluOp = 4'b0000;
    opA   = 32'd0;
    opB   = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkValue("reset.result", result, 32'd0);
    checkValue("reset.rem", remainder, 32'd0);
    checkValue("reset.zero", {31'd0, zero}, 32'd1);
    checkValue("reset.busy", {31'd0, busy}, 32'd0);
    checkValue("reset.done", {31'd0, done}, 32'd0);

    // Single-cycle ops issued back to back
    runSimple("add", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    runSimple("sub", 4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE);
    runSimple("nor", 4'b0111, 32'd0, 32'd0, 32'hFFFF_FFFF);
    runSimple("xor", 4'b1001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    runSimple("slt", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    runSimple("sltFalse", 4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    runSimple("or", 4'b0110, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834);
    runSimple("undef", 4'b1100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000);
    @(negedge clk);
    start = 1'b0;

    // Multiply
    runLong("mul", 4'b0011, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'd0, -1);
    runLong("mulMax", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, -1);

    // Divide
    runLong("div", 4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, -1);
    runLong("divSmall", 4'b0100, 32'd7, 32'd100, 32'd0, 32'd7, -1);
    runLong("divZero", 4'b0100, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, -1);

    // Start while busy is ignored; done pulses once and outputs hold
    runLong("divIgnore", 4'b0100, 32'd1000, 32'd3, 32'd333, 32'd1, 5);
    @(posedge clk);
    #1;
    checkValue("divIgnore.singleDone", {31'd0, done}, 32'd0);
    checkValue("divIgnore.hold", result, 32'd333);
    checkValue("divIgnore.holdRem", remainder, 32'd1);

    // Start in the done cycle of a DIV is accepted
    runLong("divB2b", 4'b0100, 32'd81, 32'd9, 32'd9, 32'd0, -1);
    start = 1'b1;
    aluOp = 4'b0101;
    opA   = 32'hFF00_FF00;
    opB   = 32'h0FF0_0FF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkValue("andB2b.done", {31'd0, done}, 32'd1);
    checkValue("andB2b.result", result, 32'h0F00_0F00);
    checkValue("andB2b.rem", remainder, 32'd0);

    // Reset at iteration 10 of a MUL discards it
    @(negedge clk);
    start = 1'b1;
    aluOp = 4'b0011;
    opA   = 32'd3;
    opB   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkValue("rstMid.busyBefore", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkValue("rstMid.result", result, 32'd0);
    checkValue("rstMid.rem", remainder, 32'd0);
    checkValue("rstMid.zero", {31'd0, zero}, 32'd1);
    checkValue("rstMid.busy", {31'd0, busy}, 32'd0);
    checkValue("rstMid.done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) doneSeen++;
    end
    checkValue("rstMid.noDone", doneSeen, 32'd0);
    checkValue("rstMid.resultAfter", result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execution stage that consumes the 4-bit ALU operation code produced by the ALU control decoder, plus two 32-bit operands, and produces a 32-bit result, remainder and zero flag. Logic, add/subtract and compare operations complete in one cycle. Multiply and divide run iteratively over 32 cycles under a start/busy/done handshake, which the pipeline control uses to stall.

## Interface
- No parameters; datapath width fixed at 32 bits, op code width at 4 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only on an edge where busy=0
- aluOp  in  4  operation code from ALU control; sampled with start
- opA  in  32  first operand; sampled with start
- opB  in  32  second operand; sampled with start
- result  out  32  registered result of last completed operation
- remainder  out  32  DIV remainder; 0 after any other op
- zero  out  1  registered (result == 0)
- busy  out  1  high while MUL/DIV iterates
- done  out  1  one-cycle pulse when result/remainder/zero update

## Operation
- Op map:
  - 0000 NOP → result 0
  - 0001 ADD → A+B, mod 2^32
  - 0010 SUB → A−B, mod 2^32
  - 0011 MUL → low 32 bits of A×B
  - 0100 DIV → unsigned A/B; remainder A%B
  - 0101 AND
  - 0110 OR
  - 0111 NOR
  - 1000 SLT → 1 if signed A<B, else 0
  - 1001 XOR
  - 1010–1111 → result 0, remainder 0
- Overflow is never flagged; ADD/SUB wrap.
- States:
  - IDLE: busy=0.
  - On accepted start with a single-cycle op: write result, remainder=0 and zero; pulse done; stay in IDLE.
  - On accepted start with 0011: latch operands, clear accumulator and counter, go to MUL.
  - On accepted start with 0100: latch operands, clear accumulator and counter, go to DIV.
  - MUL: shift-add, one multiplier bit per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
  - Counter 0..31. After iteration 31, write outputs, pulse done, return to IDLE.
- Divide by zero still takes 32 iterations; result=32'hFFFFFFFF, remainder=opA.
- start while busy=1 is ignored. It is not queued, and aluOp/opA/opB changes have no effect on the running operation.
- result/remainder/zero hold their values between done pulses.

## Timing
- Reset (async assert, any time, including mid-MUL/DIV): state IDLE, counter 0, result 0, remainder 0, zero 1, busy 0, done 0. In-flight operation is discarded with no done pulse.
- Single-cycle op accepted at edge E0: outputs valid and done=1 from E0 until E1; busy stays 0.
- MUL/DIV accepted at edge E0: busy=1 from E0.
  - Iterations occur on edges E1..E32.
  - At E32: outputs update, busy=0, done=1 until E33.
- Latency: 1 cycle for simple ops, 32 cycles for MUL/DIV.
- Back-to-back: start may be high in the done cycle of MUL/DIV (busy=0) and is accepted at that edge.
- Back-to-back: consecutive single-cycle ops may issue every cycle, with done high continuously.
- done is never high while busy is high.

## Test plan
- Reset: hold rst_n=0, then release → result=0, remainder=0, zero=1, busy=0, done=0. Assert rst_n=0 at iteration 10 of a MUL → same values immediately, no done pulse afterwards.
- Single-cycle ops, one per cycle:
  - ADD 0xFFFFFFFF+1 → result 0, zero=1
  - SUB 5−7 → 0xFFFFFFFE
  - NOR 0,0 → 0xFFFFFFFF
  - XOR 0xF0F0,0xFF00 → 0x0FF0
  - SLT −1 vs 1 → 1
  - Each with done=1 one cycle after start.
- MUL 0x00010003 × 0x00020005 → result 0x000B000F, busy high 32 cycles, done exactly 32 cycles after accept. MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
- DIV:
  - 100/7 → result 14, remainder 2.
  - 7/100 → result 0, remainder 7.
  - 55/0 → result 0xFFFFFFFF, remainder 55.
  - Each with 32-cycle latency.
- Start while busy: issue DIV, then pulse start with ADD 1+1 at cycle 5 → ignored; DIV result intact, single done pulse.
- Start in the done cycle → accepted; a following AND completes 1 cycle later.
- Undefined op 1100 → result 0, zero=1, done after 1 cycle.
